fll_cfg_arbiter: RTL and testbench
==================================

Name: fll_cfg_arbiter

Overview:
Shares the single FLL configuration port among NUM_REQ requesters, for example the SoC peripheral bridge, the boot sequencer and the debug unit. Uses round-robin arbitration with one transaction in flight. Holds the FLL request until the FLL acks, then returns the ack and read data to the winning requester. Sits between the requesters and fll_mia in the ref-clock domain.

Parameters:
NUM_REQ, 3, number of requesters (2..8)
TIMEOUT_CYCLES, 1024, max cycles waiting for FLL ack (used only with FLL_CFG_TIMEOUT_EN)

Ports:
ref_clk_i  in  1  clock (FLL reference clock domain)
rstn_i  in  1  asynchronous active-low reset
req_i  in  NUM_REQ  per-requester request, held high until its ack_o pulse
wrn_i  in  NUM_REQ  per-requester 1=write, 0=read
add_i  in  2*NUM_REQ  per-requester register address, requester k at bits [2k+1:2k]
data_i  in  32*NUM_REQ  per-requester write data, requester k at bits [32k+31:32k]
ack_o  out  NUM_REQ  one-cycle completion pulse to the granted requester
err_o  out  NUM_REQ  one-cycle error pulse, coincident with ack_o (timeout)
r_data_o  out  32  read data, valid in the ack_o cycle
fll_cfg_req_o  out  1  to FLL cfg_req
fll_cfg_wrn_o  out  1  to FLL cfg_wrn
fll_cfg_add_o  out  2  to FLL cfg_add
fll_cfg_data_o  out  32  to FLL cfg_data
fll_cfg_ack_i  in  1  from FLL cfg_ack (pulse; r_data valid with it)
fll_cfg_r_data_i  in  32  from FLL cfg_r_data

Behaviour:
- Reset, asynchronous:
  - FSM goes to IDLE and rr pointer to 0.
  - All outputs are 0. This covers ack_o, err_o, r_data_o, all fll_cfg_* outputs, the holding registers and the grant index.
- FSM states: IDLE, BUSY, DONE.
- IDLE:
  - If any req_i bit is set, pick the first set bit searching upward from the rr pointer, wrapping at NUM_REQ.
  - Register grant index, wrn, add and data into holding registers, then go to BUSY.
  - fll_cfg_req_o rises in the first BUSY cycle, one cycle after the request is sampled.
- BUSY:
  - fll_cfg_req_o=1. fll_cfg_wrn_o, fll_cfg_add_o and fll_cfg_data_o are driven from the holding registers and are stable for the whole transaction.
  - On fll_cfg_ack_i=1: capture fll_cfg_r_data_i into r_data_o, drop fll_cfg_req_o on the next edge, go to DONE.
  - fll_cfg_ack_i in IDLE or DONE is ignored.
- DONE:
  - ack_o[grant]=1 for exactly one cycle. r_data_o stays valid and holds until the next capture.
  - rr pointer becomes (grant+1) mod NUM_REQ, then go to IDLE.
- Latency: FLL ack in BUSY cycle n gives ack_o in cycle n+1. The minimum request-to-ack is 3 cycles, when the FLL acks in the first BUSY cycle.
- Requester rule: drop req_i in the cycle after ack_o. The arbiter samples requests in IDLE, so the requester just served is already low.
- Writes: r_data_o still captures fll_cfg_r_data_i; its value is don't-care to requesters.
- Simultaneous requests: exactly one grant per transaction; the others wait. A requester is never starved: at most NUM_REQ-1 transactions are served ahead of it.
- A requester that drops req_i mid-transaction does not abort it. The FLL transaction completes and ack_o still pulses.
- Reset mid-transaction: fll_cfg_req_o drops immediately (asynchronously) and no ack_o is issued.

Optional Feature:
FLL_CFG_TIMEOUT_EN
- Defined:
  - A counter clears on BUSY entry and increments each BUSY cycle.
  - If it reaches TIMEOUT_CYCLES without fll_cfg_ack_i, drop fll_cfg_req_o, load r_data_o with FLL_CFG_ERR_DATA (32'hBADACCE5) and go to DONE.
  - In DONE, assert ack_o[grant] and err_o[grant] together.
  - An ack arriving in the same cycle as expiry wins: normal completion, no error.
- Undefined: no counter; BUSY waits indefinitely; err_o is tied to 0.

Decomposition:
- Package fll_cfg_pkg:
  - FSM state enum.
  - FLL register address constants: FLL_ADDR_STATUS=2'd0, FLL_ADDR_CFG1=2'd1, FLL_ADDR_CFG2=2'd2, FLL_ADDR_INTEG=2'd3.
  - FLL_CFG_ERR_DATA.
- Sub-module fll_cfg_rr_pick: combinational round-robin picker.
  - Inputs: req vector and pointer.
  - Outputs: grant index and a valid flag.

Test Plan:
1. Reset release, then requester 0 writes add=1, data=32'h0000_1234 with FLL ack after 2 cycles -> FLL sees req/wrn=1/add=1/data=32'h1234 stable; ack_o[0] pulses 1 cycle after fll ack; err_o=0.
2. Requester 2 reads add=0 with FLL r_data=32'hC0DE_0001 -> r_data_o=32'hC0DE_0001 in the ack_o[2] cycle.
3. All three requesters continuously re-requesting from reset -> grant order 0,1,2,0,1,2; no two transactions overlap on fll_cfg_req_o.
4. Request 1 held while requester 0 re-requests every time -> requester 1 is served no later than the second transaction.
5. rstn_i asserted in BUSY -> fll_cfg_req_o=0 asynchronously; no ack_o; after release the first grant goes to the lowest set req_i bit (pointer 0).
6. With FLL_CFG_TIMEOUT_EN, TIMEOUT_CYCLES=16 and FLL never acks -> req drops after 16 BUSY cycles; ack_o and err_o pulse together; r_data_o=32'hBADACCE5. Repeat with ack exactly at expiry -> no error.

Source files
------------

// File: rtl/fll_cfg_pkg.sv
// rtl/fll_cfg_pkg.sv - shared types and constants for the FLL configuration port arbiter
package fll_cfg_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fll_cfg_state_e;

  localparam logic [1:0] FLL_ADDR_STATUS = 2'd0;
  localparam logic [1:0] FLL_ADDR_CFG1   = 2'd1;
  localparam logic [1:0] FLL_ADDR_CFG2   = 2'd2;
  localparam logic [1:0] FLL_ADDR_INTEG  = 2'd3;

  // Returned to the requester when the FLL never answers.
  localparam logic [31:0] FLL_CFG_ERR_DATA = 32'hBADACCE5;

endpackage

// File: rtl/fll_cfg_rr_pick.sv
// rtl/fll_cfg_rr_pick.sv - combinational round-robin picker
// Returns the first set request at or above ptr_i, wrapping at NUM_REQ.
module fll_cfg_rr_pick #(
  parameter int NUM_REQ = 3,
  parameter int IDX_W   = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [IDX_W-1:0]   ptr_i,
  output logic [IDX_W-1:0]   grant_o,
  output logic               valid_o
);

  logic [2*NUM_REQ-1:0] rot;
  logic [IDX_W:0]       sum;

  // Rotating a doubled copy puts the pointer's requester at bit 0; scanning
  // downward lets the lowest offset overwrite any higher one.
  always_comb begin
    rot     = {req_i, req_i} >> ptr_i;
    sum     = '0;
    valid_o = 1'b0;
    for (int j = NUM_REQ - 1; j >= 0; j--) begin
      if (rot[j]) begin
        sum     = {1'b0, ptr_i} + (IDX_W+1)'(j);
        valid_o = 1'b1;
      end
    end
    if (sum >= (IDX_W+1)'(NUM_REQ)) begin
      sum = sum - (IDX_W+1)'(NUM_REQ);
    end
    grant_o = sum[IDX_W-1:0];
  end

endmodule

// File: rtl/fll_cfg_arbiter.sv
// rtl/fll_cfg_arbiter.sv - round-robin arbiter sharing one FLL configuration port
// Optional FLL_CFG_TIMEOUT_EN: abort a transaction after TIMEOUT_CYCLES BUSY cycles with err_o.
module fll_cfg_arbiter
  import fll_cfg_pkg::*;
#(
  parameter int NUM_REQ        = 3,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic                    ref_clk_i,
  input  logic                    rstn_i,
  input  logic [NUM_REQ-1:0]      req_i,
  input  logic [NUM_REQ-1:0]      wrn_i,
  input  logic [2*NUM_REQ-1:0]    add_i,
  input  logic [32*NUM_REQ-1:0]   data_i,
  output logic [NUM_REQ-1:0]      ack_o,
  output logic [NUM_REQ-1:0]      err_o,
  output logic [31:0]             r_data_o,
  output logic                    fll_cfg_req_o,
  output logic                    fll_cfg_wrn_o,
  output logic [1:0]              fll_cfg_add_o,
  output logic [31:0]             fll_cfg_data_o,
  input  logic                    fll_cfg_ack_i,
  input  logic [31:0]             fll_cfg_r_data_i
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("fll_cfg_arbiter: NUM_REQ must be 2..8");
  end
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fll_cfg_arbiter: TIMEOUT_CYCLES must be at least 1");
  end

  fll_cfg_state_e   state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] grant_q, grant_d;
  logic             wrn_q, wrn_d;
  logic [1:0]       add_q, add_d;
  logic [31:0]      data_q, data_d;
  logic [31:0]      rdata_q, rdata_d;

  logic [IDX_W-1:0] pick_idx;
  logic             pick_valid;
  logic             sel_wrn;
  logic [1:0]       sel_add;
  logic [31:0]      sel_data;

`ifdef FLL_CFG_TIMEOUT_EN
  localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             err_q, err_d;
`endif

  fll_cfg_rr_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req_i   (req_i),
    .ptr_i   (ptr_q),
    .grant_o (pick_idx),
    .valid_o (pick_valid)
  );

  always_comb begin
    sel_wrn  = 1'b0;
    sel_add  = '0;
    sel_data = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (pick_idx == IDX_W'(k)) begin
        sel_wrn  = wrn_i[k];
        sel_add  = add_i[2*k +: 2];
        sel_data = data_i[32*k +: 32];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    wrn_d   = wrn_q;
    add_d   = add_q;
    data_d  = data_q;
    rdata_d = rdata_q;
`ifdef FLL_CFG_TIMEOUT_EN
    cnt_d   = cnt_q;
    err_d   = err_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          wrn_d   = sel_wrn;
          add_d   = sel_add;
          data_d  = sel_data;
          state_d = ST_BUSY;
`ifdef FLL_CFG_TIMEOUT_EN
          cnt_d   = '0;
          err_d   = 1'b0;
`endif
        end
      end
      ST_BUSY: begin
        // An ack coinciding with expiry takes priority over the timeout.
        if (fll_cfg_ack_i) begin
          rdata_d = fll_cfg_r_data_i;
          state_d = ST_DONE;
        end
`ifdef FLL_CFG_TIMEOUT_EN
        else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          rdata_d = FLL_CFG_ERR_DATA;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
`endif
      end
      ST_DONE: begin
        ptr_d   = (grant_q == IDX_W'(NUM_REQ - 1)) ? '0 : grant_q + 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge ref_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      wrn_q   <= 1'b0;
      add_q   <= '0;
      data_q  <= '0;
      rdata_q <= '0;
`ifdef FLL_CFG_TIMEOUT_EN
      cnt_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      wrn_q   <= wrn_d;
      add_q   <= add_d;
      data_q  <= data_d;
      rdata_q <= rdata_d;
`ifdef FLL_CFG_TIMEOUT_EN
      cnt_q   <= cnt_d;
      err_q   <= err_d;
`endif
    end
  end

  // Request follows the state register, so an asynchronous reset drops it at once.
  assign fll_cfg_req_o  = (state_q == ST_BUSY);
  assign fll_cfg_wrn_o  = wrn_q;
  assign fll_cfg_add_o  = add_q;
  assign fll_cfg_data_o = data_q;
  assign r_data_o       = rdata_q;

  always_comb begin
    ack_o = '0;
    err_o = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (state_q == ST_DONE && grant_q == IDX_W'(k)) begin
        ack_o[k] = 1'b1;
`ifdef FLL_CFG_TIMEOUT_EN
        err_o[k] = err_q;
`endif
      end
    end
  end

endmodule

// File: tb/tb_fll_cfg_arbiter.sv
// tb/tb_fll_cfg_arbiter.sv - directed self-checking bench for fll_cfg_arbiter
// Exercises the FLL_CFG_TIMEOUT_EN path when that macro is defined.
module tb_fll_cfg_arbiter;

  logic        clk = 1'b0;
  logic        rstn_i = 1'b0;
  logic [2:0]  req_i = '0;
  logic [2:0]  wrn_i = '0;
  logic [5:0]  add_i = '0;
  logic [95:0] data_i = '0;
  logic [2:0]  ack_o;
  logic [2:0]  err_o;
  logic [31:0] r_data_o;
  logic        fll_cfg_req_o;
  logic        fll_cfg_wrn_o;
  logic [1:0]  fll_cfg_add_o;
  logic [31:0] fll_cfg_data_o;
  logic        fll_cfg_ack_i = 1'b0;
  logic [31:0] fll_cfg_r_data_i = '0;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  fll_cfg_arbiter #(
    .NUM_REQ        (3),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .ref_clk_i        (clk),
    .rstn_i           (rstn_i),
    .req_i            (req_i),
    .wrn_i            (wrn_i),
    .add_i            (add_i),
    .data_i           (data_i),
    .ack_o            (ack_o),
    .err_o            (err_o),
    .r_data_o         (r_data_o),
    .fll_cfg_req_o    (fll_cfg_req_o),
    .fll_cfg_wrn_o    (fll_cfg_wrn_o),
    .fll_cfg_add_o    (fll_cfg_add_o),
    .fll_cfg_data_o   (fll_cfg_data_o),
    .fll_cfg_ack_i    (fll_cfg_ack_i),
    .fll_cfg_r_data_i (fll_cfg_r_data_i)
  );

  task automatic do_reset();
    rstn_i        = 1'b0;
    req_i         = '0;
    fll_cfg_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    rstn_i = 1'b1;
  endtask

  task automatic test_reset();
    rstn_i = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++;
    if ({ack_o, err_o, r_data_o, fll_cfg_req_o, fll_cfg_wrn_o, fll_cfg_add_o, fll_cfg_data_o} !== 74'd0)
      $display("FAIL reset_outs: got %h want 0", {ack_o, err_o, r_data_o, fll_cfg_req_o, fll_cfg_wrn_o, fll_cfg_add_o, fll_cfg_data_o});
    else n_pass++;
    rstn_i = 1'b1;
    @(negedge clk);
    n_checks++;
    if ({ack_o, fll_cfg_req_o} !== 4'd0)
      $display("FAIL reset_idle: ack_o=%b req=%b want 0", ack_o, fll_cfg_req_o);
    else n_pass++;
  endtask

  task automatic test_write();
    req_i  = 3'b001;
    wrn_i  = 3'b001;
    add_i  = 6'b000001;
    data_i = {64'd0, 32'h0000_1234};
    @(negedge clk);
    n_checks++;
    if ({fll_cfg_req_o, fll_cfg_wrn_o, fll_cfg_add_o, fll_cfg_data_o} !== {1'b1, 1'b1, 2'd1, 32'h0000_1234})
      $display("FAIL wr_busy1: req/wrn/add/data=%b/%b/%0d/%h want 1/1/1/00001234", fll_cfg_req_o, fll_cfg_wrn_o, fll_cfg_add_o, fll_cfg_data_o);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({fll_cfg_req_o, fll_cfg_wrn_o, fll_cfg_add_o, fll_cfg_data_o, ack_o} !== {1'b1, 1'b1, 2'd1, 32'h0000_1234, 3'b000})
      $display("FAIL wr_busy2: req/wrn/add/data/ack=%b/%b/%0d/%h/%b want 1/1/1/00001234/000", fll_cfg_req_o, fll_cfg_wrn_o, fll_cfg_add_o, fll_cfg_data_o, ack_o);
    else n_pass++;
    fll_cfg_ack_i    = 1'b1;
    fll_cfg_r_data_i = 32'hDEAD_0000;
    @(negedge clk);
    fll_cfg_ack_i = 1'b0;
    n_checks++;
    if ({ack_o, err_o, fll_cfg_req_o} !== {3'b001, 3'b000, 1'b0})
      $display("FAIL wr_ack: ack/err/req=%b/%b/%b want 001/000/0", ack_o, err_o, fll_cfg_req_o);
    else n_pass++;
    req_i = 3'b000;
    @(negedge clk);
    n_checks++;
    if (ack_o !== 3'b000) $display("FAIL wr_ack_once: ack_o=%b want 000", ack_o);
    else n_pass++;
  endtask

  // Pointer is 1 after the write; only requester 2 asks.
  task automatic test_read();
    req_i  = 3'b100;
    wrn_i  = 3'b011;
    add_i  = {2'd0, 2'd3, 2'd2};
    data_i = {32'hAAAA_0002, 32'hAAAA_0001, 32'hAAAA_0000};
    @(negedge clk);
    n_checks++;
    if ({fll_cfg_req_o, fll_cfg_wrn_o, fll_cfg_add_o} !== {1'b1, 1'b0, 2'd0})
      $display("FAIL rd_busy: req/wrn/add=%b/%b/%0d want 1/0/0", fll_cfg_req_o, fll_cfg_wrn_o, fll_cfg_add_o);
    else n_pass++;
    fll_cfg_ack_i    = 1'b1;
    fll_cfg_r_data_i = 32'hC0DE_0001;
    @(negedge clk);
    fll_cfg_ack_i    = 1'b0;
    fll_cfg_r_data_i = 32'h0;
    n_checks++;
    if ({ack_o, r_data_o} !== {3'b100, 32'hC0DE_0001})
      $display("FAIL rd_ack: ack/r_data=%b/%h want 100/c0de0001", ack_o, r_data_o);
    else n_pass++;
    req_i = 3'b000;
    @(negedge clk);
    n_checks++;
    if ({ack_o, r_data_o} !== {3'b000, 32'hC0DE_0001})
      $display("FAIL rd_hold: ack/r_data=%b/%h want 000/c0de0001", ack_o, r_data_o);
    else n_pass++;
  endtask

  task automatic test_round_robin();
    int nacks = 0;
    do_reset();
    wrn_i = 3'b000;
    add_i = {2'd2, 2'd1, 2'd0};
    req_i = 3'b111;
    for (int cyc = 0; cyc < 60 && nacks < 6; cyc++) begin
      @(negedge clk);
      if (ack_o !== 3'b000) begin
        n_checks++;
        if (ack_o !== (3'b001 << (nacks % 3)))
          $display("FAIL rr_grant: txn %0d ack_o=%b want %b", nacks, ack_o, 3'b001 << (nacks % 3));
        else n_pass++;
        n_checks++;
        if (fll_cfg_req_o !== 1'b0) $display("FAIL rr_overlap: txn %0d req=%b want 0", nacks, fll_cfg_req_o);
        else n_pass++;
        nacks++;
      end
      if (fll_cfg_req_o && !fll_cfg_ack_i) begin
        n_checks++;
        if (fll_cfg_add_o !== 2'(nacks % 3))
          $display("FAIL rr_add: txn %0d add=%0d want %0d", nacks, fll_cfg_add_o, nacks % 3);
        else n_pass++;
        fll_cfg_ack_i = 1'b1;
      end else begin
        fll_cfg_ack_i = 1'b0;
      end
    end
    req_i         = 3'b000;
    fll_cfg_ack_i = 1'b0;
    n_checks++;
    if (nacks != 6) $display("FAIL rr_count: acks=%0d want 6", nacks);
    else n_pass++;
  endtask

  task automatic test_no_starve();
    int   nacks = 0;
    logic seen1 = 1'b0;
    do_reset();
    req_i = 3'b011;
    for (int cyc = 0; cyc < 40 && nacks < 2; cyc++) begin
      @(negedge clk);
      if (ack_o !== 3'b000) begin
        if (ack_o[1]) seen1 = 1'b1;
        if (nacks == 0) begin
          n_checks++;
          if (ack_o !== 3'b001) $display("FAIL ns_first: ack_o=%b want 001", ack_o);
          else n_pass++;
        end
        nacks++;
      end
      fll_cfg_ack_i = fll_cfg_req_o && !fll_cfg_ack_i;
    end
    req_i         = 3'b000;
    fll_cfg_ack_i = 1'b0;
    n_checks++;
    if (seen1 !== 1'b1) $display("FAIL ns_served: req1 served=%b want 1 within 2 txns", seen1);
    else n_pass++;
  endtask

  task automatic test_drop_mid();
    do_reset();
    req_i = 3'b010;
    @(negedge clk);
    req_i = 3'b000;
    @(negedge clk);
    n_checks++;
    if (fll_cfg_req_o !== 1'b1) $display("FAIL drop_hold: req=%b want 1", fll_cfg_req_o);
    else n_pass++;
    fll_cfg_ack_i = 1'b1;
    @(negedge clk);
    fll_cfg_ack_i = 1'b0;
    n_checks++;
    if (ack_o !== 3'b010) $display("FAIL drop_ack: ack_o=%b want 010", ack_o);
    else n_pass++;
  endtask

  task automatic test_reset_busy();
    int got = 0;
    do_reset();
    add_i = {2'd2, 2'd1, 2'd0};
    req_i = 3'b100;
    @(negedge clk);
    n_checks++;
    if (fll_cfg_req_o !== 1'b1) $display("FAIL rst_pre: req=%b want 1", fll_cfg_req_o);
    else n_pass++;
    #2 rstn_i = 1'b0;
    req_i = 3'b110;
    #1;
    n_checks++;
    if (fll_cfg_req_o !== 1'b0) $display("FAIL rst_async: req=%b want 0", fll_cfg_req_o);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({ack_o, fll_cfg_req_o} !== 4'd0) $display("FAIL rst_no_ack: ack/req=%b/%b want 000/0", ack_o, fll_cfg_req_o);
    else n_pass++;
    rstn_i = 1'b1;
    for (int cyc = 0; cyc < 10 && got == 0; cyc++) begin
      @(negedge clk);
      if (ack_o !== 3'b000) begin
        got = 1;
        n_checks++;
        if (ack_o !== 3'b010) $display("FAIL rst_first_grant: ack_o=%b want 010", ack_o);
        else n_pass++;
      end
      fll_cfg_ack_i = fll_cfg_req_o && !fll_cfg_ack_i;
    end
    req_i         = 3'b000;
    fll_cfg_ack_i = 1'b0;
    n_checks++;
    if (got != 1) $display("FAIL rst_timeout: ack_o seen=%0d want 1", got);
    else n_pass++;
  endtask

`ifdef FLL_CFG_TIMEOUT_EN
  task automatic test_timeout();
    int busy = 0;
    do_reset();
    wrn_i = 3'b000;
    add_i = 6'b000011;
    req_i = 3'b001;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (fll_cfg_req_o) busy++;
      else if (busy > 0) break;
    end
    req_i = 3'b000;
    n_checks++;
    if (busy != 16) $display("FAIL to_len: busy cycles=%0d want 16", busy);
    else n_pass++;
    n_checks++;
    if ({ack_o, err_o, r_data_o} !== {3'b001, 3'b001, 32'hBADACCE5})
      $display("FAIL to_err: ack/err/r_data=%b/%b/%h want 001/001/badacce5", ack_o, err_o, r_data_o);
    else n_pass++;
    @(negedge clk);
    n_checks++;
    if ({ack_o, err_o} !== 6'd0) $display("FAIL to_once: ack/err=%b/%b want 000/000", ack_o, err_o);
    else n_pass++;

    busy             = 0;
    fll_cfg_r_data_i = 32'h5555_AAAA;
    req_i            = 3'b001;
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge clk);
      if (fll_cfg_req_o) begin
        busy++;
        fll_cfg_ack_i = (busy == 16);
      end else if (busy > 0) begin
        break;
      end
    end
    fll_cfg_ack_i = 1'b0;
    req_i         = 3'b000;
    n_checks++;
    if ({ack_o, err_o, r_data_o} !== {3'b001, 3'b000, 32'h5555_AAAA})
      $display("FAIL to_race: ack/err/r_data=%b/%b/%h want 001/000/5555aaaa", ack_o, err_o, r_data_o);
    else n_pass++;
    n_checks++;
    if (busy != 16) $display("FAIL to_race_len: busy cycles=%0d want 16", busy);
    else n_pass++;
  endtask
`else
  task automatic test_no_timeout();
    int busy = 0;
    do_reset();
    req_i            = 3'b001;
    fll_cfg_r_data_i = 32'h1357_9BDF;
    for (int cyc = 0; cyc < 80; cyc++) begin
      @(negedge clk);
      if (fll_cfg_req_o) begin
        busy++;
        fll_cfg_ack_i = (busy == 40);
      end else if (busy > 0) begin
        break;
      end
    end
    fll_cfg_ack_i = 1'b0;
    req_i         = 3'b000;
    n_checks++;
    if (busy != 40) $display("FAIL nto_len: busy cycles=%0d want 40", busy);
    else n_pass++;
    n_checks++;
    if ({ack_o, err_o, r_data_o} !== {3'b001, 3'b000, 32'h1357_9BDF})
      $display("FAIL nto_ack: ack/err/r_data=%b/%b/%h want 001/000/13579bdf", ack_o, err_o, r_data_o);
    else n_pass++;
  endtask
`endif

  initial begin
    test_reset();
    test_write();
    test_read();
    test_round_robin();
    test_no_starve();
    test_drop_mid();
    test_reset_busy();
`ifdef FLL_CFG_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
